// File: rtl/fifo_rd_stream_adapter.sv
// ---------------------------------------------------------------------------
// fifo_rd_stream_adapter
//
// Read-side adapter for the MAC's asynchronous FIFO, in the read clock domain.
// It pops the FIFO and presents the words as a valid/ready stream. The
// FIFO's one-cycle read latency is hidden by a two-entry output buffer
// (head + skid), so the stream sustains one word per clock under any
// backpressure without losing or duplicating words.
//
// Ports:
//   clk_rd         in   read-domain clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   fifo_data_out  in   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty     in   FIFO empty flag (read-domain synchronous)
//   fifo_rd_en     out  FIFO pop strobe (combinational)
//   m_tdata        out  stream data (registered, head of buffer)
//   m_tvalid       out  stream valid (registered)
//   m_tready       in   downstream accept
//   words_out      out  saturating transfer counter  (FIFO_RD_STATS_EN only)
//   stall_cnt      out  saturating starve counter    (FIFO_RD_STATS_EN only)
//
// Optional feature macro: FIFO_RD_STATS_EN adds the two statistics counters.
// ---------------------------------------------------------------------------
module fifo_rd_stream_adapter #(
  parameter int FIFO_DATA_WIDTH = 8
) (
  input  logic                       clk_rd,
  input  logic                       reset_n,
  input  logic [FIFO_DATA_WIDTH-1:0] fifo_data_out,
  input  logic                       fifo_empty,
  output logic                       fifo_rd_en,
  output logic [FIFO_DATA_WIDTH-1:0] m_tdata,
  output logic                       m_tvalid,
  input  logic                       m_tready
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [15:0]                words_out,
  output logic [15:0]                stall_cnt
`endif
);

  logic [1:0]                 count_q, count_d;
  logic                       inflight_q, inflight_d;
  logic [FIFO_DATA_WIDTH-1:0] head_q, head_d;
  logic [FIFO_DATA_WIDTH-1:0] skid_q, skid_d;
  logic                       m_tvalid_q, m_tvalid_d;

  logic                       transfer_s;
  logic [2:0]                 occupancy_s;

  assign transfer_s  = m_tvalid_q & m_tready;
  // Words held or on their way, after this cycle's transfer leaves. Never
  // underflows: a transfer implies count_q >= 1.
  assign occupancy_s = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, transfer_s};

  // Pop only when the returning word is guaranteed a buffer slot; reset_n
  // gating keeps the strobe low for the whole reset interval.
  assign fifo_rd_en  = reset_n & ~fifo_empty & (occupancy_s < 3'd2);

  assign m_tdata     = head_q;
  assign m_tvalid    = m_tvalid_q;

  // Buffer next-state: capture of the in-flight word and/or departure of head.
  always_comb begin
    count_d    = count_q;
    head_d     = head_q;
    skid_d     = skid_q;
    inflight_d = fifo_rd_en;
    case ({inflight_q, transfer_s})
      2'b10: begin
        // Capture only: fill head if empty, otherwise the skid slot.
        if (count_q == 2'd0) begin
          head_d  = fifo_data_out;
          count_d = 2'd1;
        end else begin
          skid_d  = fifo_data_out;
          count_d = 2'd2;
        end
      end
      2'b01: begin
        // Transfer only: skid (if any) advances into head.
        count_d = count_q - 2'd1;
        if (count_q == 2'd2) begin
          head_d = skid_q;
        end else begin
          head_d = head_q;
        end
      end
      2'b11: begin
        // Capture and transfer together: occupancy is unchanged.
        if (count_q == 2'd2) begin
          head_d = skid_q;
          skid_d = fifo_data_out;
        end else begin
          head_d = fifo_data_out;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
    m_tvalid_d = (count_d != 2'd0);
  end

  // Buffer, in-flight and valid registers.
  always_ff @(posedge clk_rd or negedge reset_n) begin
    if (!reset_n) begin
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      skid_q     <= '0;
      m_tvalid_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      m_tvalid_q <= m_tvalid_d;
    end
  end

`ifdef FIFO_RD_STATS_EN
  logic [15:0] words_q, words_d;
  logic [15:0] stall_q, stall_d;
  logic        seen_xfer_q, seen_xfer_d;

  // Saturating counters; stalls count only once the stream has started.
  always_comb begin
    seen_xfer_d = seen_xfer_q | transfer_s;
    if (transfer_s && (words_q != 16'hFFFF)) begin
      words_d = words_q + 16'd1;
    end else begin
      words_d = words_q;
    end
    if (seen_xfer_q && !m_tvalid_q && m_tready && fifo_empty && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk_rd or negedge reset_n) begin
    if (!reset_n) begin
      words_q     <= 16'd0;
      stall_q     <= 16'd0;
      seen_xfer_q <= 1'b0;
    end else begin
      words_q     <= words_d;
      stall_q     <= stall_d;
      seen_xfer_q <= seen_xfer_d;
    end
  end

  assign words_out = words_q;
  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
module tb_fifo_rd_stream_adapter;

  logic       clk_rd = 1'b0;
  logic       reset_n;
  logic [7:0] fifo_data_out;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready;
`ifdef FIFO_RD_STATS_EN
  logic [15:0] words_out;
  logic [15:0] stall_cnt;
`endif

  fifo_rd_stream_adapter #(.FIFO_DATA_WIDTH(8)) dut (
    .clk_rd        (clk_rd),
    .reset_n       (reset_n),
    .fifo_data_out (fifo_data_out),
    .fifo_empty    (fifo_empty),
    .fifo_rd_en    (fifo_rd_en),
    .m_tdata       (m_tdata),
    .m_tvalid      (m_tvalid),
    .m_tready      (m_tready)
`ifdef FIFO_RD_STATS_EN
    ,
    .words_out     (words_out),
    .stall_cnt     (stall_cnt)
`endif
  );

  always #5 clk_rd = ~clk_rd;

  int n_checks = 0;
  int n_err    = 0;

  // Environment: FIFO contents and the scoreboard of popped words (pop order).
  logic [7:0] fifo_q[$];
  logic [7:0] sb_q[$];
  int         outstanding = 0;   // words popped from the FIFO but not yet transferred
  bit         inflight_m  = 1'b0;
  bit         prev_hold   = 1'b0;
  logic [7:0] prev_d      = 8'h00;
  bit         seen_x      = 1'b0;
  int         stall_exp   = 0;
  int         words_exp   = 0;
  int         xfer_total  = 0;
  logic [7:0] last_word   = 8'h00;

  bit         s_rd, s_v, s_rdy, s_e, s_x;
  logic [7:0] s_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock: sample and check at negedge, then update the environment after the edge.
  task automatic tick();
    logic [7:0] w;
    bit         exp_rd;
    @(negedge clk_rd);
    s_rd  = fifo_rd_en;
    s_v   = m_tvalid;
    s_rdy = m_tready;
    s_d   = m_tdata;
    s_e   = fifo_empty;
    s_x   = s_v & s_rdy;
    if (reset_n) begin
      check("rd_en_while_empty", {31'd0, s_e & s_rd}, 32'd0);
      exp_rd = !s_e && ((outstanding - int'(s_x)) < 2);
      check("rd_en", {31'd0, s_rd}, {31'd0, exp_rd});
      check("tvalid", {31'd0, s_v}, {31'd0, ((outstanding - int'(inflight_m)) != 0)});
      check("count_le2", {31'd0, (outstanding <= 2)}, 32'd1);
      if (prev_hold) begin
        check("hold_valid", {31'd0, s_v}, 32'd1);
        check("hold_data", {24'd0, s_d}, {24'd0, prev_d});
      end
      if (s_x) begin
        check("word_order", {24'd0, s_d}, (sb_q.size() != 0) ? {24'd0, sb_q[0]} : 32'hFFFF_FFFF);
        if (words_exp < 65535) words_exp++;
      end
      if (seen_x && !s_v && s_rdy && s_e && (stall_exp < 65535)) stall_exp++;
    end
    @(posedge clk_rd);
    #1;
    if (reset_n) begin
      if (s_x) begin
        if (sb_q.size() != 0) void'(sb_q.pop_front());
        outstanding--;
        xfer_total++;
        last_word = s_d;
        seen_x    = 1'b1;
      end
      prev_hold  = s_v & !s_rdy;
      prev_d     = s_d;
      inflight_m = s_rd;
      if (s_rd) begin
        if (fifo_q.size() != 0) begin
          w = fifo_q.pop_front();
          fifo_data_out = w;
          sb_q.push_back(w);
        end
        outstanding++;
      end else begin
        fifo_data_out = 8'($urandom);
      end
      fifo_empty = (fifo_q.size() == 0);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    outstanding = 0;
    inflight_m  = 1'b0;
    prev_hold   = 1'b0;
    seen_x      = 1'b0;
    stall_exp   = 0;
    words_exp   = 0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    m_tready = 1'b1;
    while ((fifo_q.size() != 0 || outstanding != 0) && n < 200) begin
      tick();
      n++;
    end
    check(tag, {31'd0, (n < 200)}, 32'd1);
  endtask

  logic [5:0] t1_rd = 6'b000111;
  logic [5:0] t1_v  = 6'b011100;
  logic [7:0] t1_d [6] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};

  initial begin
    int pulses, xfers, start, cyc, pct, pushed;
    bit found;
    logic [7:0] first;

    // Reset with the FIFO preloaded; the read strobe must stay low in reset.
    reset_n       = 1'b0;
    m_tready      = 1'b1;
    fifo_empty    = 1'b1;
    fifo_data_out = 8'h00;
    #2;
    push(8'h11); push(8'h22); push(8'h33);
    #1;
    check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("rst_tdata", {24'd0, m_tdata}, 32'd0);
    @(posedge clk_rd);
    #1;
    reset_n = 1'b1;

    // Three preloaded words stream out back-to-back.
    for (int t = 0; t < 6; t++) begin
      tick();
      check("t1_rd_en", {31'd0, s_rd}, {31'd0, t1_rd[t]});
      check("t1_tvalid", {31'd0, s_v}, {31'd0, t1_v[t]});
      if (t1_v[t]) check("t1_tdata", {24'd0, s_d}, {24'd0, t1_d[t]});
    end

    // Backpressure: only two reads while stalled, then 8 words back-to-back.
    m_tready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      pulses += int'(s_rd);
    end
    check("bp_rd_pulses", pulses, 32'd2);
    check("bp_tvalid", {31'd0, s_v}, 32'd1);
    check("bp_tdata", {24'd0, s_d}, 32'h0000_00A0);
    m_tready = 1'b1;
    start = xfer_total;
    for (int i = 0; i < 8; i++) tick();
    check("bp_b2b_count", xfer_total - start, 32'd8);
    check("bp_last_word", {24'd0, last_word}, 32'h0000_00A7);
    drain("bp_drain");

    // FIFO empties mid-stream: gap with tvalid low, then the late word.
    push(8'h01); push(8'h02);
    start = xfer_total;
    for (int i = 0; i < 4; i++) tick();
    check("gap_first_two", xfer_total - start, 32'd2);
    check("gap_word2", {24'd0, last_word}, 32'h0000_0002);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("gap_tvalid_low", {31'd0, s_v}, 32'd0);
    end
    push(8'h03);
    for (int i = 0; i < 3; i++) tick();
    check("gap_total", xfer_total - start, 32'd3);
    check("gap_word3", {24'd0, last_word}, 32'h0000_0003);

    // Async reset with words buffered and one read in flight.
    m_tready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'hB0 + 8'(i));
    for (int i = 0; i < 4; i++) tick();
    m_tready = 1'b1;
    tick();
    check("rst2_pre_rd", {31'd0, s_rd}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst2_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("rst2_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check("rst2_tdata", {24'd0, m_tdata}, 32'd0);
    model_reset();
    tick(); tick();
    reset_n = 1'b1;
    found = 1'b0;
    first = 8'h00;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (s_x) begin
        found = 1'b1;
        first = s_d;
      end
    end
    check("rst2_found", {31'd0, found}, 32'd1);
    check("rst2_first_word", {24'd0, first}, 32'h0000_00B3);
    drain("rst2_drain");

    // Random traffic: random FIFO fill and random backpressure.
    start  = xfer_total;
    pushed = 0;
    cyc    = 0;
    pct    = 100;
    while ((pushed < 1000 || fifo_q.size() != 0 || outstanding != 0) && cyc < 20000) begin
      if (cyc % 40 == 0) begin
        case ($urandom_range(0, 3))
          0: pct = 20;
          1: pct = 50;
          2: pct = 90;
          default: pct = 100;
        endcase
      end
      m_tready = ($urandom_range(0, 99) < pct);
      if (pushed < 1000 && $urandom_range(0, 99) < 55) begin
        push(8'($urandom));
        pushed++;
      end
      tick();
      cyc++;
    end
    check("rand_done", {31'd0, (cyc < 20000)}, 32'd1);
    check("rand_count", xfer_total - start, 32'd1000);

`ifdef FIFO_RD_STATS_EN
    // Long stream saturates the transfer counter; an idle gap adds stalls.
    m_tready = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      push(8'(i));
      tick();
    end
    drain("stats_drain");
    check("stats_words_sat", {16'd0, words_out}, 32'h0000_FFFF);
    check("stats_words_model", {16'd0, words_out}, words_exp);
    for (int i = 0; i < 7; i++) tick();
    check("stats_stall", {16'd0, stall_cnt}, stall_exp);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
